// File: rtl/holy_axi_ram_if.sv
// AXI4 bundle shared by the core's master port and the RAM slave.
// Slave modport: AW/W/AR/B-ready inputs in, B/R responses and readies out.
interface axi_if;
    logic        aclk;
    logic        aresetn;

    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;

    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport slave (
        input  aclk, aresetn,
        input  awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport master (
        output aclk, aresetn,
        output awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );
endinterface

// File: rtl/holy_axi_ram.sv
// Single-ported byte-writable AXI4 slave RAM; one FSM serializes bursts.
// Ports: clk, rst_n (async active-low), s_axi (AXI4 slave, IDs tied 0).
module holy_axi_ram #(
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter              INIT_FILE   = ""
) (
    input logic  clk,
    input logic  rst_n,
    axi_if.slave s_axi
);
    localparam int AW = $clog2(DEPTH_WORDS);

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        W_DATA,
        W_RESP,
        R_DATA
    } state_t;

    state_t state;
    state_t state_nx;

    logic          prio_rd;
    logic [AW-1:0] start;
    logic [7:0]    len;
    logic [7:0]    beat;
    logic [1:0]    resp;
    logic          drop;
    logic          rlast_q;
    logic          rzero;
    logic [31:0]   mem_q;
    logic [31:0]   mem [DEPTH_WORDS];

    logic          ar_rdy;
    logic          aw_rdy;
    logic [31:0]   ar_off;
    logic [31:0]   aw_off;
    logic [AW-1:0] ar_idx;
    logic [AW-1:0] aw_idx;
    logic [1:0]    ar_cls;
    logic [1:0]    aw_cls;
    logic [AW-1:0] rd_next;
    logic [AW-1:0] fetch_idx;
    logic [AW-1:0] wr_idx;
    logic          fetch_en;
    logic          we;
    logic          unused_bits;

    // Offsets below BASE wrap to huge values, so one
    // upper-bits test covers both ends of the window.
    function automatic logic [1:0] classify(
        input logic [31:0] off,
        input logic [2:0]  size
    );
        if ((off >> (AW + 2)) != 32'd0) return DECERR;
        if (size != 3'b010) return SLVERR;
        return OKAY;
    endfunction

    assign ar_off = s_axi.araddr - BASE_ADDR;
    assign aw_off = s_axi.awaddr - BASE_ADDR;
    assign ar_idx = ar_off[AW+1:2];
    assign aw_idx = aw_off[AW+1:2];
    assign ar_cls = classify(ar_off, s_axi.arsize);
    assign aw_cls = classify(aw_off, s_axi.awsize);

    assign unused_bits = ^{s_axi.awburst, s_axi.arburst,
                           s_axi.aclk, s_axi.aresetn};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        ar_rdy   = 1'b0;
        aw_rdy   = 1'b0;
        unique case (state)
            IDLE: begin
                ar_rdy = s_axi.arvalid &
                         (~s_axi.awvalid | prio_rd);
                aw_rdy = s_axi.awvalid &
                         (~s_axi.arvalid | ~prio_rd);
                if (ar_rdy)      state_nx = R_DATA;
                else if (aw_rdy) state_nx = W_DATA;
            end
            W_DATA:
                if (s_axi.wvalid && beat == len)
                    state_nx = W_RESP;
            W_RESP:
                if (s_axi.bready) state_nx = IDLE;
            R_DATA:
                if (s_axi.rready && rlast_q)
                    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_rd <= 1'b1;
            start   <= '0;
            len     <= '0;
            beat    <= '0;
            resp    <= OKAY;
            drop    <= 1'b0;
            rlast_q <= 1'b0;
            rzero   <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (ar_rdy) begin
                        prio_rd <= ~prio_rd;
                        start   <= ar_idx;
                        len     <= s_axi.arlen;
                        beat    <= '0;
                        resp    <= ar_cls;
                        rlast_q <= (s_axi.arlen == 8'd0);
                        rzero   <= (ar_cls != OKAY);
                    end else if (aw_rdy) begin
                        prio_rd <= ~prio_rd;
                        start   <= aw_idx;
                        len     <= s_axi.awlen;
                        beat    <= '0;
                        resp    <= aw_cls;
                        drop    <= (aw_cls != OKAY);
                    end
                end
                W_DATA: begin
                    if (s_axi.wvalid) begin
                        beat <= beat + 8'd1;
                        if ((s_axi.wlast != (beat == len)) &&
                            resp != DECERR)
                            resp <= SLVERR;
                    end
                end
                R_DATA: begin
                    if (s_axi.rready && !rlast_q) begin
                        beat    <= beat + 8'd1;
                        rlast_q <= (beat + 8'd1) == len;
                    end
                end
                default: ;
            endcase
        end
    end

    // The next read word is fetched on the same edge
    // that retires the current beat.
    assign rd_next   = start + AW'(beat) + AW'(1);
    assign wr_idx    = start + AW'(beat);
    assign fetch_en  = ar_rdy |
                       ((state == R_DATA) & s_axi.rready & ~rlast_q);
    assign fetch_idx = ar_rdy ? ar_idx : rd_next;
    assign we        = (state == W_DATA) & s_axi.wvalid & ~drop;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++)
                if (s_axi.wstrb[b])
                    mem[wr_idx][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
        end
        if (fetch_en) mem_q <= mem[fetch_idx];
    end

    assign s_axi.awready = aw_rdy;
    assign s_axi.arready = ar_rdy;
    assign s_axi.wready  = (state == W_DATA);
    assign s_axi.bvalid  = (state == W_RESP);
    assign s_axi.bresp   = resp;
    assign s_axi.bid     = 4'd0;
    assign s_axi.rvalid  = (state == R_DATA);
    assign s_axi.rresp   = resp;
    assign s_axi.rlast   = rlast_q;
    assign s_axi.rid     = 4'd0;
    assign s_axi.rdata   = rzero ? 32'h0 : mem_q;
endmodule
